// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared NES system-bus addresses, DMA state encoding and bus-mux select encoding
package nes_bus_pkg;
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_e;
    typedef enum logic {
        BUS_CPU = 1'b0,
        BUS_DMA = 1'b1
    } bus_sel_e;
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA that stalls the CPU and copies one page to the PPU OAM data port
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic        bus_sel_dma,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    input  logic [7:0]  bus_rdata
);
    import nes_bus_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_e state;
    bus_sel_e   sel;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] rd_buf;
    logic       par;
    logic       trigger;

    assign trigger     = cpu_we && cpu_addr == DMA_REG_ADDR;
    assign bus_sel_dma = sel == BUS_DMA;
    assign bus_wdata   = rd_buf;

    // Outputs are loaded alongside each transition so they follow the state they describe.
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state      <= DMA_IDLE;
            sel        <= BUS_CPU;
            page       <= '0;
            idx        <= '0;
            rd_buf     <= '0;
            par        <= 1'b0;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
        end else begin
            par <= ~par;
            case (state)
                DMA_IDLE: begin
                    if (trigger) begin
                        page       <= cpu_wdata;
                        idx        <= '0;
                        state      <= DMA_HALT;
                        cpu_rdy    <= 1'b0;
                        dma_active <= 1'b1;
                    end
                end
                DMA_HALT: begin
                    // Reads must land on even parity; an odd HALT goes straight to READ.
                    state <= par ? DMA_READ : DMA_ALIGN;
                    if (par) begin
                        sel      <= BUS_DMA;
                        bus_addr <= {page, idx};
                    end
                end
                DMA_ALIGN: begin
                    state    <= DMA_READ;
                    sel      <= BUS_DMA;
                    bus_addr <= {page, idx};
                end
                DMA_READ: begin
                    rd_buf   <= bus_rdata;
                    state    <= DMA_WRITE;
                    bus_addr <= OAM_DATA_ADDR;
                    bus_we   <= 1'b1;
                end
                DMA_WRITE: begin
                    bus_we <= 1'b0;
                    if (idx == LAST_IDX) begin
                        state      <= DMA_IDLE;
                        sel        <= BUS_CPU;
                        bus_addr   <= '0;
                        cpu_rdy    <= 1'b1;
                        dma_active <= 1'b0;
                    end else begin
                        idx      <= idx + 8'd1;
                        state    <= DMA_READ;
                        bus_addr <= {page, idx + 8'd1};
                    end
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: table-driven and randomized checks of oam_dma_ctrl against a page-copy model
module tb_oam_dma_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy, dma_active, bus_sel_dma, bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic [7:0]  mem [0:65535];

    always #5 clk = ~clk;
    assign bus_rdata = mem[bus_addr];

    oam_dma_ctrl dut (
        .clk_ph1(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .dma_active(dma_active), .bus_sel_dma(bus_sel_dma), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;
    typedef struct {
        logic [7:0] page;
        int         par;
        bit         inject;
        int         stall;
    } vec_t;

    acc_t log_q[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, stall = 0, nosel_stall = 0, inv_bad = 0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (bus_sel_dma) log_q.push_back('{bus_we, bus_addr, bus_wdata});
        if (!cpu_rdy) begin
            stall++;
            if (!bus_sel_dma) nosel_stall++;
        end
        if ((!bus_sel_dma && (bus_addr != 16'h0 || bus_we)) || dma_active != !cpu_rdy) inv_bad++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_q.delete();
        stall = 0;
        nosel_stall = 0;
    endtask

    // Model: a page copy is 256 (read page:i, write $2004 <- mem[page:i]) pairs after 1 HALT and an ALIGN on even parity.
    task automatic run_dma(input logic [7:0] pg, input int want_par, input bit inject, input int exp_stall);
        int halt_par, n, bad;
        if (want_par >= 0 && (cyc + 1) % 2 != want_par) tick();
        halt_par = (cyc + 1) % 2;
        clear_log();
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0;
        check("halt_rdy_low", cpu_rdy, 0);
        n = 0;
        while (!cpu_rdy && n < 700) begin
            cpu_we = inject && n == 100;
            cpu_addr = cpu_we ? 16'h4014 : 16'h0;
            cpu_wdata = 8'h05;
            tick();
            n++;
        end
        cpu_we = 1'b0; cpu_addr = 16'h0;
        check("done_in_time", n < 700, 1);
        check("stall_len", stall, exp_stall > 0 ? exp_stall : (halt_par ? 513 : 514));
        check("no_bus_stall", nosel_stall, halt_par ? 1 : 2);
        check("access_count", log_q.size(), 512);
        bad = 0;
        for (int i = 0; i < 512 && i < log_q.size(); i++) begin
            if (i % 2 == 0) begin
                if (log_q[i].we !== 1'b0 || log_q[i].addr !== {pg, 8'(i / 2)}) bad++;
            end else begin
                if (log_q[i].we !== 1'b1 || log_q[i].addr !== 16'h2004 || log_q[i].data !== mem[{pg, 8'(i / 2)}]) bad++;
            end
        end
        check("sequence_bad", bad, 0);
        if (log_q.size() >= 512) begin
            check("last_read_addr", log_q[510].addr, {pg, 8'hFF});
            check("last_write_data", log_q[511].data, mem[{pg, 8'hFF}]);
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   n, sz;
        logic [7:0] pg;
        vecs = '{'{8'h02, 1, 1'b0, 513}, '{8'h02, 0, 1'b0, 514}, '{8'hFF, 1, 1'b0, 513}, '{8'h02, 0, 1'b1, 514}};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i);
        tick();
        check("rst_cpu_rdy", cpu_rdy, 1);
        check("rst_dma_active", dma_active, 0);
        check("rst_bus_sel", bus_sel_dma, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_we", bus_we, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int v = 0; v < 4; v++) begin
            run_dma(vecs[v].page, vecs[v].par, vecs[v].inject, vecs[v].stall);
            repeat (3) tick();
        end

        // Reset in the WRITE cycle for idx $80 abandons the copy.
        clear_log();
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0;
        n = 0;
        while (!(bus_we && log_q.size() == 258) && n < 600) begin
            tick();
            n++;
        end
        check("reach_idx80", n < 600, 1);
        if (log_q.size() >= 258) check("idx80_read_addr", log_q[256].addr, 16'h0280);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cpu_rdy", cpu_rdy, 1);
        check("abort_bus_sel", bus_sel_dma, 0);
        sz = log_q.size();
        repeat (20) tick();
        check("abort_no_access", log_q.size(), sz);
        run_dma(8'h03, -1, 1'b0, -1);

        // Non-trigger accesses and a trigger under reset.
        clear_log();
        cpu_we = 1'b1; cpu_addr = 16'h4013; cpu_wdata = 8'h02;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h4014;
        repeat (4) tick();
        cpu_addr = 16'h0;
        check("nontrigger_stall", stall, 0);
        check("nontrigger_access", log_q.size(), 0);
        rst = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h04;
        tick();
        rst = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0;
        repeat (4) tick();
        check("rst_trigger_stall", stall, 0);
        check("rst_trigger_rdy", cpu_rdy, 1);

        repeat (6) begin
            pg = 8'($urandom);
            for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_dma(pg, -1, 1'b0, -1);
        end

        check("invariants_bad", inv_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
